b_io_l3_in_serialize_b_m_axi_fwft_fifo: RTL
===========================================

B_IO_L3_IN_SERIALIZE_B_M_AXI_FWFT_FIFO -- requirements
Module: B_IO_L3_in_serialize_B_m_axi_fwft_fifo

Interface
REQ-001 SHALL have parameter MEM_STYLE, default "auto": ram_style attribute passed to the storage array.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 6: storage address width.
REQ-004 SHALL have parameter DEPTH, default 64: total word capacity, 2 <= DEPTH <= 2**ADDR_WIDTH.
REQ-005 SHALL have parameter AFULL_LVL, default DEPTH-4: almost_full threshold.
REQ-006 SHALL have parameter AEMPTY_LVL, default 4: almost_empty threshold.
REQ-007 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port clk_en, input, 1: global clock enable; state frozen while low.
REQ-010 SHALL have port s_valid, input, 1: write-side data valid.
REQ-011 SHALL have port s_ready, output, 1: write-side space available.
REQ-012 SHALL have port s_data, input, DATA_WIDTH: write payload.
REQ-013 SHALL have port m_valid, output, 1: head word present on m_data.
REQ-014 SHALL have port m_ready, input, 1: consumer accepts head word.
REQ-015 SHALL have port m_data, output, DATA_WIDTH: head word, first-word-fall-through.
REQ-016 SHALL have port count, output, ADDR_WIDTH+1: words accepted and not yet popped.
REQ-017 SHALL have ports almost_full and almost_empty, output, 1 each: count >= AFULL_LVL; count <= AEMPTY_LVL.

Function
REQ-018 SHALL accept a push only on an edge with clk_en & s_valid & s_ready, and pop only on an edge with clk_en & m_valid & m_ready.
REQ-019 SHALL drive s_ready = (count < DEPTH) from registers only; no combinational path from m_ready to s_ready.
REQ-020 SHALL, when full, refuse a push even when a pop occurs on the same edge.
REQ-021 SHALL, with push and pop on the same edge, keep count unchanged and preserve order.
REQ-022 SHALL deliver words strictly in push order, with no loss or duplication.
REQ-023 SHALL, for a push into an empty FIFO at edge t, raise m_valid after edge t+2 (storage write, then registered read into output stage).
REQ-024 SHALL hold m_data and m_valid stable while m_valid & ~m_ready; m_data is don't-care while m_valid is low.
REQ-025 SHALL prefetch the next word so that back-to-back pops sustain one word per cycle when count >= 2.
REQ-026 SHALL wrap read and write pointers from DEPTH-1 to 0; DEPTH need not be a power of two.
REQ-027 SHALL update count, almost_full and almost_empty registered, on the same edge as the push/pop causing the change.
REQ-028 SHALL, while clk_en is low, change no register and perform no transfer regardless of s_valid/m_ready.
REQ-029 SHALL count words held in the output stage and in prefetch within count; capacity is exactly DEPTH.

Reset
REQ-030 SHALL, on reset high at an edge (clk_en ignored), set count=0, pointers=0, m_valid=0, s_ready=1, almost_empty=1, almost_full=(AFULL_LVL==0), m_data=0.
REQ-031 SHALL discard all stored words on reset mid-operation; storage array contents are not reset.
REQ-032 SHALL accept a push on the first edge after reset deasserts.

Structure
REQ-033 SHALL place no typedefs in a shared package; all sizing is by module parameters.
REQ-034 SHALL instantiate one sub-module B_IO_L3_in_serialize_B_m_axi_sdp_ram: simple dual-port array, write port and registered-read port, 1-cycle read latency, read enable, MEM_STYLE and rw_addr_collision attributes.
REQ-035 SHALL keep pointers, count, prefetch control and output stage in the top module.

Verification
REQ-036 SHALL test: reset, then push 0xA5 at edge 1, m_ready=1 -> m_valid high after edge 3, m_data=0xA5, count 1 then 0.
REQ-037 SHALL test: push 64 words 0..63 with m_ready=0 -> s_ready low after 64th, count=64, almost_full high from count 60; 65th push refused.
REQ-038 SHALL test: full FIFO, s_valid=1 and m_ready=1 for one edge -> pop of 0 only, count=63, s_ready=1 next cycle.
REQ-039 SHALL test: continuous push/pop for 200 cycles (pointer wrap) -> output sequence equals input sequence, one word/cycle throughput.
REQ-040 SHALL test: clk_en low for 5 cycles mid-stream with s_valid=m_ready=1 -> count, m_data, pointers unchanged.
REQ-041 SHALL test: reset asserted with count=10 -> m_valid=0, count=0 next cycle; next pushed word 0x1234 is first popped.

Source files
------------

// File: rtl/b_io_l3_in_serialize_b_m_axi_fwft_fifo_pkg.sv
// Shared helpers for the FWFT FIFO slice; sizing stays on module parameters.
package b_io_l3_in_serialize_b_m_axi_fwft_fifo_pkg;

  // Pointer increment with wrap at an arbitrary (non power-of-two) depth.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/b_io_l3_in_serialize_b_m_axi_fwft_fifo_sdp_ram.sv
// Simple dual-port storage: one write port, one registered read port (1-cycle latency).
module b_io_l3_in_serialize_b_m_axi_fwft_fifo_sdp_ram #(
  parameter string MEM_STYLE  = "auto",
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 6,
  parameter int    DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] q
);

  if (MEM_STYLE == "") begin : g_style_check
    $error("MEM_STYLE must name a ram_style");
  end

  (* ram_style = MEM_STYLE, rw_addr_collision = "yes" *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/b_io_l3_in_serialize_b_m_axi_fwft_fifo.sv
// First-word-fall-through FIFO: RAM, one prefetch stage (RAM read register), one output stage.
module b_io_l3_in_serialize_b_m_axi_fwft_fifo
  import b_io_l3_in_serialize_b_m_axi_fwft_fifo_pkg::*;
#(
  parameter string MEM_STYLE  = "auto",
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 6,
  parameter int    DEPTH      = 64,
  parameter int    AFULL_LVL  = DEPTH - 4,
  parameter int    AEMPTY_LVL = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_W  = (ADDR_WIDTH+1)'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_W = (ADDR_WIDTH+1)'(AEMPTY_LVL);
  localparam logic [ADDR_WIDTH:0] ONE_W    = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0]   mem_cnt, mem_cnt_next, count_next;
  logic                  ram_valid;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  push, pop, rd, out_load;

  // mem_cnt counts words still in the array; count also includes prefetch and output stage.
  always_comb begin
    push     = clk_en & s_valid & s_ready;
    pop      = clk_en & m_valid & m_ready;
    out_load = clk_en & ram_valid & (~m_valid | pop);
    rd       = clk_en & (mem_cnt != '0) & (~ram_valid | out_load);

    mem_cnt_next = mem_cnt;
    if (push & ~rd)      mem_cnt_next = mem_cnt + ONE_W;
    else if (rd & ~push) mem_cnt_next = mem_cnt - ONE_W;

    count_next = count;
    if (push & ~pop)      count_next = count + ONE_W;
    else if (pop & ~push) count_next = count - ONE_W;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr         <= '0;
      rptr         <= '0;
      mem_cnt      <= '0;
      count        <= '0;
      ram_valid    <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      s_ready      <= 1'b1;
      almost_full  <= (AFULL_LVL == 0);
      almost_empty <= 1'b1;
    end else if (clk_en) begin
      if (push) wptr <= ADDR_WIDTH'(wrap_inc(32'(wptr), DEPTH));
      if (rd)   rptr <= ADDR_WIDTH'(wrap_inc(32'(rptr), DEPTH));
      mem_cnt      <= mem_cnt_next;
      count        <= count_next;
      s_ready      <= count_next < DEPTH_W;
      almost_full  <= count_next >= AFULL_W;
      almost_empty <= count_next <= AEMPTY_W;
      if (rd)            ram_valid <= 1'b1;
      else if (out_load) ram_valid <= 1'b0;
      if (out_load) begin
        m_valid <= 1'b1;
        m_data  <= ram_q;
      end else if (pop) begin
        m_valid <= 1'b0;
      end
    end
  end

  b_io_l3_in_serialize_b_m_axi_fwft_fifo_sdp_ram #(
    .MEM_STYLE (MEM_STYLE),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wptr),
    .wdata(s_data),
    .re   (rd),
    .raddr(rptr),
    .q    (ram_q)
  );

endmodule
